// File: rtl/morse_pkg.sv
// Shared symbol codes, ASCII constants and sequencer state encoding for the Morse key front end.
package morse_pkg;

   localparam int unsigned SYM_W  = 2;
   localparam int unsigned CHAR_W = 8;

   typedef logic [SYM_W-1:0]  sym_t;
   typedef logic [CHAR_W-1:0] char_t;

   localparam sym_t  SYM_IDLE    = 2'b00;
   localparam sym_t  SYM_DOT     = 2'b01;
   localparam sym_t  SYM_DASH    = 2'b10;
   localparam sym_t  SYM_SEND    = 2'b11;
   localparam char_t ASCII_SPACE = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MARK,
      ST_GAP,
      ST_CAPTURE,
      ST_SEND,
      ST_WGAP
   } seq_state_t;

endpackage

// File: rtl/morse_key_sequencer_if.sv
// Character output stream of the Morse key sequencer: one-entry valid/ready buffer.
interface morse_key_sequencer_if;
   import morse_pkg::*;

   char_t char_out;
   logic  char_valid;
   logic  char_ready;

   modport master (output char_out, output char_valid, input char_ready);
   modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Prescaler plus saturating Morse unit counter; clear restarts timing from the current cycle.
module morse_unit_timer #(
   parameter int unsigned TICKS_PER_UNIT = 1000,
   parameter int unsigned UNIT_W         = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   output logic [UNIT_W-1:0] units
);

   localparam int unsigned PRE_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_UNIT - 1);

   logic [PRE_W-1:0] presc;

   // The clearing cycle is itself the first tick, so L cycles of a state give floor(L/TICKS_PER_UNIT).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         units <= '0;
      end else if (clear) begin
         presc <= PRE_W'(1);
         units <= '0;
      end else if (presc == PRE_LAST) begin
         presc <= '0;
         if (units != '1) units <= units + UNIT_W'(1);
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

endmodule

// File: rtl/morse_key_sequencer.sv
// Straight-key timing front end for the Morse letter decoder with a one-entry character buffer.
// Optional MORSE_KEY_SYNC_EN: key passes through a 2-flop synchronizer before use.
module morse_key_sequencer
   import morse_pkg::*;
#(
   parameter int unsigned TICKS_PER_UNIT   = 1000,
   parameter int unsigned DASH_UNITS       = 2,
   parameter int unsigned LETTER_GAP_UNITS = 3,
   parameter int unsigned WORD_GAP_UNITS   = 7,
   parameter int unsigned UNIT_W           = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key,
   input  char_t                  letter_in,
   output sym_t                   symbol,
   output logic                   overflow,
   morse_key_sequencer_if.master  io
);

   localparam logic [UNIT_W-1:0] DASH_U   = UNIT_W'(DASH_UNITS);
   localparam logic [UNIT_W-1:0] LETTER_U = UNIT_W'(LETTER_GAP_UNITS);
   localparam logic [UNIT_W-1:0] WORD_U   = UNIT_W'(WORD_GAP_UNITS);

   seq_state_t        state, state_nxt;
   sym_t              sym_nxt;
   logic              word_open, word_open_nxt;
   logic              timer_clr_c, push_c;
   char_t             push_data_c;
   logic [UNIT_W-1:0] units;
   logic              key_s;
   char_t             char_q;
   logic              valid_q;

`ifdef MORSE_KEY_SYNC_EN
   logic [1:0] key_sync;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) key_sync <= '0;
      else        key_sync <= {key_sync[0], key};
   end
   assign key_s = key_sync[1];
`else
   assign key_s = key;
`endif

   morse_unit_timer #(
      .TICKS_PER_UNIT (TICKS_PER_UNIT),
      .UNIT_W         (UNIT_W)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clr_c),
      .units (units)
   );

   // Next state, symbol pulse, buffer push and timer restart on MARK/GAP entry.
   always_comb begin
      state_nxt     = state;
      sym_nxt       = SYM_IDLE;
      word_open_nxt = word_open;
      timer_clr_c   = 1'b0;
      push_c        = 1'b0;
      push_data_c   = letter_in;
      unique case (state)
         ST_IDLE: begin
            if (key_s) begin
               state_nxt   = ST_MARK;
               timer_clr_c = 1'b1;
            end
         end
         ST_MARK: begin
            if (!key_s) begin
               state_nxt   = ST_GAP;
               timer_clr_c = 1'b1;
               sym_nxt     = (units < DASH_U) ? SYM_DOT : SYM_DASH;
            end
         end
         ST_GAP: begin
            if (units == LETTER_U) begin
               state_nxt = ST_CAPTURE;
            end else if (key_s) begin
               state_nxt   = ST_MARK;
               timer_clr_c = 1'b1;
            end
         end
         ST_CAPTURE: begin
            state_nxt = ST_SEND;
            if (letter_in != '0) begin
               push_c        = 1'b1;
               word_open_nxt = 1'b1;
            end
         end
         ST_SEND: begin
            sym_nxt = SYM_SEND;
            if (key_s) begin
               state_nxt   = ST_MARK;
               timer_clr_c = 1'b1;
            end else begin
               state_nxt = ST_WGAP;
            end
         end
         ST_WGAP: begin
            if (key_s) begin
               state_nxt   = ST_MARK;
               timer_clr_c = 1'b1;
            end else if (units == WORD_U) begin
               state_nxt = ST_IDLE;
               if (word_open) begin
                  push_c        = 1'b1;
                  push_data_c   = ASCII_SPACE;
                  word_open_nxt = 1'b0;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A push into a full, stalled buffer is dropped and flagged sticky.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         symbol    <= SYM_IDLE;
         word_open <= 1'b0;
         char_q    <= '0;
         valid_q   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nxt;
         symbol    <= sym_nxt;
         word_open <= word_open_nxt;
         if (push_c) begin
            if (!valid_q || io.char_ready) begin
               char_q  <= push_data_c;
               valid_q <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (valid_q && io.char_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign io.char_out   = char_q;
   assign io.char_valid = valid_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with a small behavioural letter decoder (E, T, A, K).
module tb_morse_key_sequencer;
   import morse_pkg::*;

   localparam int unsigned TPU = 4;

   logic  clk   = 1'b0;
   logic  reset = 1'b0;
   logic  key   = 1'b0;
   char_t letter_in;
   sym_t  symbol;
   logic  overflow;

   int total = 0;
   int bad   = 0;

   sym_t  sym_q[$];
   char_t chr_q[$];

   logic [2:0] dec_n;
   logic [3:0] dec_pat;

   morse_key_sequencer_if io ();

   morse_key_sequencer #(.TICKS_PER_UNIT(TPU)) dut (
      .clk       (clk),
      .reset     (reset),
      .key       (key),
      .letter_in (letter_in),
      .symbol    (symbol),
      .overflow  (overflow),
      .io        (io)
   );

   always #5 clk = ~clk;

   // Decoder model: accumulates dots/dashes, 11 clears.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_n   <= '0;
         dec_pat <= '0;
      end else begin
         case (symbol)
            SYM_DOT:  begin dec_n <= dec_n + 3'd1; dec_pat <= {dec_pat[2:0], 1'b0}; end
            SYM_DASH: begin dec_n <= dec_n + 3'd1; dec_pat <= {dec_pat[2:0], 1'b1}; end
            SYM_SEND: begin dec_n <= '0; dec_pat <= '0; end
            default:  ;
         endcase
      end
   end

   always_comb begin
      case ({dec_n, dec_pat})
         {3'd1, 4'b0000}: letter_in = 8'h45;
         {3'd1, 4'b0001}: letter_in = 8'h54;
         {3'd2, 4'b0001}: letter_in = 8'h41;
         {3'd3, 4'b0101}: letter_in = 8'h4B;
         default:         letter_in = 8'h00;
      endcase
   end

   always @(posedge clk) begin
      if (symbol != SYM_IDLE) sym_q.push_back(symbol);
      if (io.char_valid && io.char_ready) chr_q.push_back(io.char_out);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int n);
      key = 1'b1;
      step(n);
      key = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] chr_at(input int i);
      return (i < chr_q.size()) ? chr_q[i] : 8'hxx;
   endfunction

   function automatic logic [1:0] sym_at(input int i);
      return (i < sym_q.size()) ? sym_q[i] : 2'bxx;
   endfunction

   function automatic void clear_logs();
      sym_q.delete();
      chr_q.delete();
   endfunction

   initial begin
      io.char_ready = 1'b1;
      step(3);
      chk("rst symbol", 32'(symbol), 32'(SYM_IDLE));
      chk("rst valid", 32'(io.char_valid), 0);
      chk("rst char", 32'(io.char_out), 0);
      chk("rst overflow", 32'(overflow), 0);
      reset = 1'b1;
      step(2);

      // 1: single dot -> 'E', then word-gap space
      clear_logs();
      press(4);
      step(1);
      chk("t1 dot pulse", 32'(symbol), 32'(SYM_DOT));
      step(1);
      chk("t1 pulse end", 32'(symbol), 32'(SYM_IDLE));
      step(12);
      chk("t1 E valid", 32'(io.char_valid), 1);
      chk("t1 E char", 32'(io.char_out), 32'h45);
      chk("t1 no send yet", 32'(symbol), 32'(SYM_IDLE));
      step(1);
      chk("t1 send pulse", 32'(symbol), 32'(SYM_SEND));
      chk("t1 E consumed", 32'(io.char_valid), 0);
      step(13);
      chk("t1 no space early", 32'(io.char_valid), 0);
      step(1);
      chk("t1 space valid", 32'(io.char_valid), 1);
      chk("t1 space char", 32'(io.char_out), 32'h20);
      step(4);

      // 2: dash dot dash -> 'K'
      clear_logs();
      press(8); step(4); press(4); step(4); press(8);
      step(50);
      chk("t2 sym count", 32'(sym_q.size()), 4);
      chk("t2 sym0", 32'(sym_at(0)), 32'(SYM_DASH));
      chk("t2 sym1", 32'(sym_at(1)), 32'(SYM_DOT));
      chk("t2 sym2", 32'(sym_at(2)), 32'(SYM_DASH));
      chk("t2 sym3", 32'(sym_at(3)), 32'(SYM_SEND));
      chk("t2 chr count", 32'(chr_q.size()), 2);
      chk("t2 K", 32'(chr_at(0)), 32'h4B);
      chk("t2 space", 32'(chr_at(1)), 32'h20);

      // 3: stalled consumer, 'T' dropped
      clear_logs();
      io.char_ready = 1'b0;
      press(4); step(16); press(8); step(16);
      chk("t3 overflow", 32'(overflow), 1);
      chk("t3 held valid", 32'(io.char_valid), 1);
      chk("t3 held char", 32'(io.char_out), 32'h45);
      io.char_ready = 1'b1;
      step(1);
      chk("t3 drained", 32'(io.char_valid), 0);
      chk("t3 overflow sticky", 32'(overflow), 1);
      step(30);
      chk("t3 chr count", 32'(chr_q.size()), 2);
      chk("t3 chr0", 32'(chr_at(0)), 32'h45);
      chk("t3 chr1", 32'(chr_at(1)), 32'h20);
      chk("t3 sym count", 32'(sym_q.size()), 4);
      chk("t3 sym2", 32'(sym_at(2)), 32'(SYM_DASH));

      // 4: key rises on the letter-gap boundary cycle
      clear_logs();
      press(4);
      step(12);
      key = 1'b1;
      step(2);
      chk("t4 E valid", 32'(io.char_valid), 1);
      chk("t4 E char", 32'(io.char_out), 32'h45);
      step(1);
      chk("t4 send pulse", 32'(symbol), 32'(SYM_SEND));
      step(7);
      key = 1'b0;
      step(50);
      chk("t4 sym count", 32'(sym_q.size()), 4);
      chk("t4 sym2", 32'(sym_at(2)), 32'(SYM_DASH));
      chk("t4 chr count", 32'(chr_q.size()), 3);
      chk("t4 T", 32'(chr_at(1)), 32'h54);
      chk("t4 space", 32'(chr_at(2)), 32'h20);

      // 5: reset during a mark
      clear_logs();
      io.char_ready = 1'b0;
      press(4); step(16);
      chk("t5 pre valid", 32'(io.char_valid), 1);
      chk("t5 pre overflow", 32'(overflow), 1);
      key = 1'b1;
      step(5);
      #2 reset = 1'b0;
      #1;
      chk("t5 rst symbol", 32'(symbol), 32'(SYM_IDLE));
      chk("t5 rst valid", 32'(io.char_valid), 0);
      chk("t5 rst overflow", 32'(overflow), 0);
      chk("t5 rst char", 32'(io.char_out), 0);
      key = 1'b0;
      step(3);
      reset = 1'b1;
      io.char_ready = 1'b1;
      step(40);
      chk("t5 no chars", 32'(chr_q.size()), 0);
      chk("t5 sym count", 32'(sym_q.size()), 2);

      // 6: very long mark saturates the unit counter
      clear_logs();
      press(2000);
      chk("t6 units sat", 32'(dut.u_timer.units), 255);
      step(1);
      chk("t6 dash pulse", 32'(symbol), 32'(SYM_DASH));
      step(50);
      chk("t6 sym count", 32'(sym_q.size()), 2);
      chk("t6 sym1", 32'(sym_at(1)), 32'(SYM_SEND));
      chk("t6 T", 32'(chr_at(0)), 32'h54);
      chk("t6 space", 32'(chr_at(1)), 32'h20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
